// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide unit. Runs a 32-step shift-add
//            multiply or a restoring divide on operand magnitudes, then fixes
//            the sign and selects the requested word. Divide-by-zero and
//            signed overflow are resolved at start and skip the iterations.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_done;
    logic [31:0] r_result;

    logic [2:0]  r_op;       // latched funct3
    logic        r_neg;      // final result must be negated
    logic [5:0]  r_cnt;      // iteration counter
    logic [63:0] r_acc;      // product accumulator
    logic [63:0] r_mcand;    // multiplicand, shifted left each step
    logic [31:0] r_q;        // multiplier (shifts right) or dividend/quotient (shifts left)
    logic [31:0] r_rem;      // partial remainder; its 33rd bit lives in w_shift
    logic [31:0] r_dvsr;     // divisor magnitude
    logic [31:0] r_res;      // staged result, published on the done edge

    // ------------------------------------------------------------------
    // Operand decode, magnitudes and special cases (used only in IDLE)
    // ------------------------------------------------------------------
    logic        w_accept;
    logic        w_in_div;
    logic        w_in_rem;
    logic        w_sgn_a;
    logic        w_sgn_b;
    logic        w_neg_a;
    logic        w_neg_b;
    logic        w_in_neg;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_div_zero;
    logic        w_ovf;
    logic        w_special;
    logic [31:0] w_special_res;

    // A start in the done cycle is dropped so the result is seen first
    assign w_accept   = (r_state == c_IDLE) && start && !r_done;
    assign w_in_div   = funct3[2];
    assign w_in_rem   = funct3[2] & funct3[1];
    // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed
    assign w_sgn_a    = funct3[2] ? ~funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
    assign w_sgn_b    = (funct3 == 3'b001) || (funct3[2] & ~funct3[0]);
    assign w_neg_a    = w_sgn_a & srcA[31];
    assign w_neg_b    = w_sgn_b & srcB[31];
    assign w_mag_a    = w_neg_a ? (~srcA + 32'd1) : srcA;
    assign w_mag_b    = w_neg_b ? (~srcB + 32'd1) : srcB;
    // Remainder takes the dividend's sign; everything else the XOR of signs
    assign w_in_neg   = w_in_rem ? w_neg_a : (w_neg_a ^ w_neg_b);
    assign w_div_zero = w_in_div && (srcB == 32'd0);
    assign w_ovf      = w_in_div && !funct3[0] && (srcA == 32'h8000_0000) &&
                        (srcB == 32'hFFFF_FFFF);
    assign w_special  = w_div_zero || w_ovf;
    assign w_special_res = w_div_zero ? (w_in_rem ? srcA : 32'hFFFF_FFFF)
                                      : (w_in_rem ? 32'd0 : 32'h8000_0000);

    // ------------------------------------------------------------------
    // Restoring divide step: shift in the next dividend bit and try
    // subtracting the divisor; a borrow in bit 32 means keep the shift.
    // ------------------------------------------------------------------
    logic [32:0] w_shift;
    logic [32:0] w_trial;

    assign w_shift = {r_rem, r_q[31]};
    assign w_trial = w_shift - {1'b0, r_dvsr};

    // ------------------------------------------------------------------
    // Sign fix-up and result select (used in FIX)
    // ------------------------------------------------------------------
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_fix_res;

    assign w_prod_fix = r_neg ? (~r_acc + 64'd1) : r_acc;
    assign w_quo_fix  = r_neg ? (~r_q + 32'd1) : r_q;
    assign w_rem_fix  = r_neg ? (~r_rem + 32'd1) : r_rem;

    // Pick the word the operation asks for
    always_comb begin
        w_fix_res = w_prod_fix[63:32];
        case (r_op)
            3'b000:         w_fix_res = w_prod_fix[31:0];
            3'b100, 3'b101: w_fix_res = w_quo_fix;
            3'b110, 3'b111: w_fix_res = w_rem_fix;
            default:        w_fix_res = w_prod_fix[63:32];
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (w_accept) w_state_nxt = w_special ? c_DONE : c_RUN;
            c_RUN:  if (r_cnt == 6'd31) w_state_nxt = c_FIX;
            c_FIX:  w_state_nxt = c_DONE;
            c_DONE: w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, fix-up and result publication
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= 3'd0;
            r_neg    <= 1'b0;
            r_cnt    <= 6'd0;
            r_acc    <= 64'd0;
            r_mcand  <= 64'd0;
            r_q      <= 32'd0;
            r_rem    <= 32'd0;
            r_dvsr   <= 32'd0;
            r_res    <= 32'd0;
            r_result <= 32'd0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == c_DONE);
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_op    <= funct3;
                        r_neg   <= w_in_neg;
                        r_cnt   <= 6'd0;
                        r_acc   <= 64'd0;
                        r_rem   <= 32'd0;
                        r_mcand <= {32'd0, w_mag_a};
                        r_q     <= w_in_div ? w_mag_a : w_mag_b;
                        r_dvsr  <= w_mag_b;
                        if (w_special) r_res <= w_special_res;
                    end
                end
                c_RUN: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (!r_op[2]) begin
                        if (r_q[0]) r_acc <= r_acc + r_mcand;
                        r_mcand <= r_mcand << 1;
                        r_q     <= r_q >> 1;
                    end else if (!w_trial[32]) begin
                        r_rem <= w_trial[31:0];
                        r_q   <= {r_q[30:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[31:0];
                        r_q   <= {r_q[30:0], 1'b0};
                    end
                end
                c_FIX: begin
                    r_res <= w_fix_res;
                end
                c_DONE: begin
                    r_result <= r_res;
                end
                default: begin
                    r_res <= r_res;
                end
            endcase
        end
    end

    assign busy   = (r_state != c_IDLE) || r_done;
    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Directed self-checking bench for muldiv_unit with hand-computed
//            results, latency, busy/done handshake and reset-abort checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    muldiv_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .srcA   (srcA),
        .srcB   (srcB),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one start pulse, accepted at the next rising edge (E0);
    // inputs are scrambled afterwards to show they were latched.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        funct3 = op;
        srcA   = a;
        srcB   = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = 3'b101;
        srcA   = 32'hDEAD_BEEF;
        srcB   = 32'h0000_0000;
    endtask

    // Wait for done counting edges after E0 (n0 already consumed), then
    // check latency, result, busy in the done cycle and the one-cycle pulse.
    task automatic wait_done(input string tag, input int n0, input int exp_lat,
                             input logic [31:0] exp_res);
        int n;
        n = n0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " result"}, result, exp_res);
        check({tag, " busy in done"}, {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, " done pulse width"}, {31'd0, done}, 32'd0);
        check({tag, " busy after done"}, {31'd0, busy}, 32'd0);
        check({tag, " result held"}, result, exp_res);
    endtask

    initial begin
        int late_done;
        reset  = 1'b1;
        start  = 1'b0;
        funct3 = 3'b000;
        srcA   = 32'd0;
        srcB   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // MUL low word and normal latency
        start_op(3'b000, 32'd7, 32'hFFFF_FFFD);
        check("mul busy after E0", {31'd0, busy}, 32'd1);
        wait_done("mul", 0, 34, 32'hFFFF_FFEB);

        // Multiply high words
        start_op(3'b001, 32'h8000_0000, 32'h8000_0000);
        wait_done("mulh", 0, 34, 32'h4000_0000);
        start_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("mulhu", 0, 34, 32'hFFFF_FFFE);
        start_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("mulhsu", 0, 34, 32'hFFFF_FFFF);

        // Signed and unsigned divide/remainder
        start_op(3'b100, 32'hFFFF_FFF9, 32'd2);
        wait_done("div", 0, 34, 32'hFFFF_FFFD);
        start_op(3'b110, 32'hFFFF_FFF9, 32'd2);
        wait_done("rem", 0, 34, 32'hFFFF_FFFF);
        start_op(3'b100, 32'd20, 32'hFFFF_FFFD);
        wait_done("div pos/neg", 0, 34, 32'hFFFF_FFFA);
        start_op(3'b110, 32'd20, 32'hFFFF_FFFD);
        wait_done("rem pos/neg", 0, 34, 32'd2);
        start_op(3'b101, 32'd100, 32'd7);
        wait_done("divu", 0, 34, 32'd14);
        start_op(3'b111, 32'd100, 32'd7);
        wait_done("remu", 0, 34, 32'd2);

        // Divide by zero and signed overflow resolve in one cycle
        start_op(3'b101, 32'd5, 32'd0);
        wait_done("divu by zero", 0, 1, 32'hFFFF_FFFF);
        start_op(3'b110, 32'd5, 32'd0);
        wait_done("rem by zero", 0, 1, 32'd5);
        start_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div overflow", 0, 1, 32'h8000_0000);
        start_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("rem overflow", 0, 1, 32'd0);

        // start while busy is ignored; pulse lands on edge E10
        start_op(3'b000, 32'd7, 32'hFFFF_FFFD);
        repeat (9) @(posedge clk);
        @(negedge clk);
        funct3 = 3'b011;
        srcA   = 32'h1234_5678;
        srcB   = 32'h0000_0100;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        wait_done("mul start ignored", 10, 34, 32'hFFFF_FFEB);

        // Reset at step 20 aborts with no later done
        start_op(3'b000, 32'd3, 32'd5);
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        late_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) late_done++;
        end
        check("no done after abort", 32'(late_done), 32'd0);

        // Fresh operation after reset
        start_op(3'b000, 32'd3, 32'd5);
        wait_done("mul after reset", 0, 34, 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
